// File: rtl/sram_fb_arbiter.sv
// sram_fb_arbiter: shares one asynchronous SRAM between a pixel writer
// (valid/ready) and the VGA scan-out prefetcher. The prefetcher fills a small
// first-word-fall-through FIFO. All SRAM pins are registered, and the block
// performs one access per clock. A single TURN cycle separates reads from
// writes so the pad drivers never fight.
module sram_fb_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 4,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk108,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        wr_be,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LVL_W = PTR_W + 2;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(BASE_ADDR + H_RES * V_RES - 1);
    localparam logic [LVL_W-1:0]  LOW_L  = LVL_W'(LOW_WATER);
    localparam logic [LVL_W-1:0]  FULL_L = LVL_W'(FIFO_DEPTH);

    // State names describe what the SRAM pins are doing in the current cycle.
    typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   scan_addr_q, scan_addr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic                underflow_q, underflow_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   dq_out_q, dq_out_d;
    logic                dq_oe_q, dq_oe_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                ub_n_q, ub_n_d;
    logic                lb_n_q, lb_n_d;

    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [LVL_W-1:0]    level;
    logic                do_read;
    logic                do_write;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic [1:0]          lane_n_d;

    // A read on the pins this cycle is data already owed to the FIFO, so it counts toward the fill level.
    assign level      = {1'b0, count_q} + LVL_W'(state_q == READ);
    assign fifo_empty = (count_q == '0);
    assign push       = (state_q == READ) && !frame_start;
    assign pop        = pix_rd && !fifo_empty && !frame_start;

    // Access decision: starving scan-out beats the writer, the writer beats opportunistic prefetch.
    always_comb begin
        state_d  = IDLE;
        do_read  = 1'b0;
        do_write = 1'b0;
        if (!rst || frame_start) begin
            state_d = IDLE;
        end else if (level <= LOW_L) begin
            if (state_q == WRITE) begin
                state_d = TURN;
            end else begin
                state_d = READ;
                do_read = 1'b1;
            end
        end else if (wr_valid) begin
            if (state_q == READ) begin
                state_d = TURN;
            end else begin
                state_d  = WRITE;
                do_write = 1'b1;
            end
        end else if (level < FULL_L) begin
            if (state_q == WRITE) begin
                state_d = TURN;
            end else begin
                state_d = READ;
                do_read = 1'b1;
            end
        end
    end

    // Byte-lane strobes: reads enable both lanes, writes follow wr_be, otherwise both lanes are off.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_n_d[gi] = do_write ? ~wr_be[gi] : ~do_read;
        end
    endgenerate

    // Next values for the registered SRAM pins. Address holds when idle; write data is zeroed when not driving.
    always_comb begin
        sram_addr_d = sram_addr_q;
        dq_out_d    = '0;
        dq_oe_d     = 1'b0;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        ub_n_d      = lane_n_d[1];
        lb_n_d      = lane_n_d[0];
        if (do_read) begin
            sram_addr_d = scan_addr_q;
            ce_n_d      = 1'b0;
            oe_n_d      = 1'b0;
        end else if (do_write) begin
            sram_addr_d = wr_addr;
            dq_out_d    = wr_data;
            dq_oe_d     = 1'b1;
            ce_n_d      = 1'b0;
            we_n_d      = 1'b0;
        end
    end

    // Scan address, FIFO bookkeeping and the sticky underflow flag.
    always_comb begin
        scan_addr_d = scan_addr_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        underflow_d = underflow_q;
        if (frame_start) begin
            scan_addr_d = BASE_A;
            count_d     = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            underflow_d = 1'b0;
        end else begin
            if (do_read) begin
                scan_addr_d = (scan_addr_q == LAST_A) ? BASE_A : scan_addr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            if (pix_rd && fifo_empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // State and pin registers. Reset forces the strobes high, which also drops any accepted write.
    always_ff @(posedge clk108) begin
        if (!rst) begin
            state_q     <= IDLE;
            scan_addr_q <= BASE_A;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            underflow_q <= 1'b0;
            sram_addr_q <= BASE_A;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            scan_addr_q <= scan_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            underflow_q <= underflow_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
        end
    end

    // Prefetch storage: the read data on the pad is captured at the edge that ends the READ cycle.
    always_ff @(posedge clk108) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= sram_dq_in;
        end
    end

    assign pix_data    = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
    assign pix_valid   = !fifo_empty;
    assign underflow   = underflow_q;
    assign wr_ready    = do_write;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = ub_n_q;
    assign sram_lb_n   = lb_n_q;

endmodule

// File: tb/tb_sram_fb_arbiter.sv
// Directed bench for sram_fb_arbiter. The main instance uses the full
// 640x480 raster with a non-zero base address. A second instance uses a
// 4x2 raster to exercise the scan wrap. The SRAM read data is modelled as a
// fixed function of the address.
module tb_sram_fb_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam logic [AW-1:0] BASE = 20'h00040;

    logic clk108 = 1'b0;
    always #5 clk108 = ~clk108;

    logic          rst, frame_start, pix_rd, wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    wr_be;

    logic [DW-1:0] pix_data, sram_dq_out, sram_dq_in;
    logic          pix_valid, underflow, wr_ready, sram_dq_oe;
    logic [AW-1:0] sram_addr;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic [DW-1:0] s_pix_data, s_dq_out, s_dq_in;
    logic          s_pix_valid, s_underflow, s_wr_ready, s_dq_oe;
    logic [AW-1:0] s_addr;
    logic          s_ce_n, s_oe_n, s_we_n, s_ub_n, s_lb_n;

    int errors = 0;
    int checks = 0;
    logic m_prev_we = 1'b1, m_prev_oe = 1'b1, s_prev_we = 1'b1, s_prev_oe = 1'b1;

    function automatic logic [DW-1:0] model(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC3C3;
    endfunction

    assign sram_dq_in = model(sram_addr);
    assign s_dq_in    = model(s_addr);

    sram_fb_arbiter #(.BASE_ADDR(32'h40)) dut (
        .clk108(clk108), .rst(rst), .frame_start(frame_start), .pix_rd(pix_rd),
        .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_ready(wr_ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n)
    );

    sram_fb_arbiter #(.H_RES(4), .V_RES(2), .BASE_ADDR(0)) u_small (
        .clk108(clk108), .rst(rst), .frame_start(frame_start), .pix_rd(pix_rd),
        .pix_data(s_pix_data), .pix_valid(s_pix_valid), .underflow(s_underflow),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_ready(s_wr_ready), .sram_addr(s_addr), .sram_dq_out(s_dq_out),
        .sram_dq_oe(s_dq_oe), .sram_dq_in(s_dq_in), .sram_ce_n(s_ce_n),
        .sram_oe_n(s_oe_n), .sram_we_n(s_we_n), .sram_ub_n(s_ub_n),
        .sram_lb_n(s_lb_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
        end
    endtask

    // Advance one clock, then check that no cycle with OE low sits directly next to a cycle with WE low.
    task automatic step();
        @(posedge clk108);
        #2;
        chk("adj_main", 32'((!m_prev_we && !sram_oe_n) || (!m_prev_oe && !sram_we_n)), 32'd0);
        chk("adj_small", 32'((!s_prev_we && !s_oe_n) || (!s_prev_oe && !s_we_n)), 32'd0);
        m_prev_we = sram_we_n;
        m_prev_oe = sram_oe_n;
        s_prev_we = s_we_n;
        s_prev_oe = s_oe_n;
        $display("t=%0t addr=%h ce_n=%b oe_n=%b we_n=%b ub_n=%b lb_n=%b oe=%b dq=%h pv=%b pd=%h uf=%b",
                 $time, sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
                 sram_dq_oe, sram_dq_out, pix_valid, pix_data, underflow);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ce_n"}, 32'(sram_ce_n), 32'd1);
        chk({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
        chk({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
        chk({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'd0);
    endtask

    task automatic chk_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic ub, input logic lb);
        chk({tag, "_we_n"}, 32'(sram_we_n), 32'd0);
        chk({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
        chk({tag, "_ce_n"}, 32'(sram_ce_n), 32'd0);
        chk({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'd1);
        chk({tag, "_addr"}, 32'(sram_addr), 32'(a));
        chk({tag, "_dq"}, 32'(sram_dq_out), 32'(d));
        chk({tag, "_ub_n"}, 32'(sram_ub_n), 32'(ub));
        chk({tag, "_lb_n"}, 32'(sram_lb_n), 32'(lb));
    endtask

    initial begin
        rst = 1'b0; frame_start = 1'b0; pix_rd = 1'b0;
        wr_valid = 1'b1; wr_addr = '0; wr_data = '0; wr_be = 2'b11;

        // Reset state, with a write request pending that must not be accepted.
        step();
        step();
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk_quiet("rst");
        chk("rst_ub_n", 32'(sram_ub_n), 32'd1);
        chk("rst_lb_n", 32'(sram_lb_n), 32'd1);
        chk("rst_addr", 32'(sram_addr), 32'(BASE));
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        wr_valid = 1'b0;
        rst = 1'b1;

        // 1: 16 back-to-back reads from BASE; the small raster wraps 7 -> 0.
        for (int k = 0; k < 16; k++) begin
            step();
            chk("t1_oe_n", 32'(sram_oe_n), 32'd0);
            chk("t1_ce_n", 32'(sram_ce_n), 32'd0);
            chk("t1_we_n", 32'(sram_we_n), 32'd1);
            chk("t1_addr", 32'(sram_addr), 32'(BASE + AW'(k)));
            chk("t6_small_addr", 32'(s_addr), 32'(k % 8));
            if (k == 0) chk("t1_pv_c2", 32'(pix_valid), 32'd0);
            if (k == 1) begin
                chk("t1_pv_c3", 32'(pix_valid), 32'd1);
                chk("t1_pd_c3", 32'(pix_data), 32'(model(BASE)));
            end
        end
        step();
        chk_quiet("t1_idle");
        step();
        chk_quiet("t1_idle2");

        // 2: pop one, let the refill read start, then hold wr_valid for 3 writes.
        pix_rd = 1'b1;
        #1;
        chk("t2_head0", 32'(pix_data), 32'(model(BASE)));
        step();
        pix_rd = 1'b0;
        #1;
        chk("t2_head1", 32'(pix_data), 32'(model(BASE + 20'd1)));
        step();
        chk("t2_read_addr", 32'(sram_addr), 32'(BASE + 20'd16));
        chk("t2_read_oe_n", 32'(sram_oe_n), 32'd0);
        wr_valid = 1'b1; wr_addr = 20'h00010; wr_data = 16'h1111; wr_be = 2'b11;
        #1;
        chk("t2_wr_ready_rd", 32'(wr_ready), 32'd0);
        step();
        chk_quiet("t2_turn");
        #1;
        chk("t2_wr_ready_a", 32'(wr_ready), 32'd1);
        step();
        chk_write("t2_w1", 20'h00010, 16'h1111, 1'b0, 1'b0);
        wr_addr = 20'h00011; wr_data = 16'h2222;
        #1;
        chk("t2_wr_ready_b", 32'(wr_ready), 32'd1);
        step();
        chk_write("t2_w2", 20'h00011, 16'h2222, 1'b0, 1'b0);
        wr_addr = 20'h00012; wr_data = 16'h3333;
        #1;
        chk("t2_wr_ready_c", 32'(wr_ready), 32'd1);
        step();
        chk_write("t2_w3", 20'h00012, 16'h3333, 1'b0, 1'b0);
        wr_valid = 1'b0;
        #1;
        chk("t2_wr_ready_d", 32'(wr_ready), 32'd0);
        step();
        chk_quiet("t2_idle");

        // 3: upper-lane-only write, then a write with no lanes enabled.
        wr_valid = 1'b1; wr_addr = 20'h00100; wr_data = 16'hABCD; wr_be = 2'b10;
        #1;
        chk("t3_wr_ready", 32'(wr_ready), 32'd1);
        step();
        chk_write("t3_be10", 20'h00100, 16'hABCD, 1'b0, 1'b1);
        wr_valid = 1'b0;
        step();
        chk_quiet("t3_after");
        wr_valid = 1'b1; wr_addr = 20'h00101; wr_data = 16'h5555; wr_be = 2'b00;
        #1;
        chk("t3_wr_ready_be00", 32'(wr_ready), 32'd1);
        step();
        chk_write("t3_be00", 20'h00101, 16'h5555, 1'b1, 1'b1);
        wr_valid = 1'b0;
        step();
        chk_quiet("t3_after_be00");

        // 4: drain 16 -> 4 while writing; at level 4 the read wins through a TURN.
        wr_valid = 1'b1; wr_addr = 20'h00200; wr_data = 16'h7777; wr_be = 2'b11;
        pix_rd = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("t4_wr_ready_hi", 32'(wr_ready), 32'd1);
            chk("t4_pix_data", 32'(pix_data), 32'(model(BASE + AW'(1 + i))));
            step();
        end
        pix_rd = 1'b0;
        #1;
        chk("t4_we_n_last", 32'(sram_we_n), 32'd0);
        chk("t4_wr_ready_lvl4", 32'(wr_ready), 32'd0);
        step();
        chk_quiet("t4_turn1");
        #1;
        chk("t4_wr_ready_turn1", 32'(wr_ready), 32'd0);
        step();
        chk("t4_read_oe_n", 32'(sram_oe_n), 32'd0);
        chk("t4_read_addr", 32'(sram_addr), 32'(BASE + 20'd17));
        #1;
        chk("t4_wr_ready_read", 32'(wr_ready), 32'd0);
        step();
        chk_quiet("t4_turn2");
        #1;
        chk("t4_wr_ready_lvl5", 32'(wr_ready), 32'd1);
        wr_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk_quiet("t4_refilled");
        chk("t4_head", 32'(pix_data), 32'(model(BASE + 20'd13)));

        // 5: flush, underflow on empty pop, clear by frame_start, scan restarts at BASE.
        frame_start = 1'b1; pix_rd = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t5_flushed_pv", 32'(pix_valid), 32'd0);
        chk("t5_uf_beaten", 32'(underflow), 32'd0);
        chk_quiet("t5_fs_idle");
        step();
        pix_rd = 1'b0;
        chk("t5_underflow_set", 32'(underflow), 32'd1);
        chk("t5_read_base", 32'(sram_addr), 32'(BASE));
        chk("t5_read_oe_n", 32'(sram_oe_n), 32'd0);
        chk("t5_pv_empty", 32'(pix_valid), 32'd0);
        step();
        chk("t5_pv_after", 32'(pix_valid), 32'd1);
        chk("t5_pd_after", 32'(pix_data), 32'(model(BASE)));
        chk("t5_uf_sticky", 32'(underflow), 32'd1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t5_uf_cleared", 32'(underflow), 32'd0);
        chk("t5_discard_pv", 32'(pix_valid), 32'd0);
        chk_quiet("t5_fs2_idle");
        step();
        chk("t5_restart_addr", 32'(sram_addr), 32'(BASE));
        chk("t5_restart_pv", 32'(pix_valid), 32'd0);
        step();
        chk("t5_restart_pd", 32'(pix_data), 32'(model(BASE)));

        // Reset during an active read returns the strobes high on that edge.
        chk("rst2_pre_oe_n", 32'(sram_oe_n), 32'd0);
        rst = 1'b0;
        step();
        chk_quiet("rst2");
        chk("rst2_addr", 32'(sram_addr), 32'(BASE));
        chk("rst2_pv", 32'(pix_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
